// File: rtl/motion_pkg.sv
// Shared types and physics defaults for the character motion controller.
package motion_pkg;

  typedef enum logic [1:0] {
    MS_GROUND = 2'd0,
    MS_RISE   = 2'd1,
    MS_FALL   = 2'd2
  } motion_state_t;

  // Default geometry and physics, overridable per instance.
  localparam int DEF_CORDW      = 16;
  localparam int DEF_H_RES      = 800;
  localparam int DEF_SPR_W_PIX  = 38;
  localparam int DEF_INIT_X     = 100;
  localparam int DEF_GROUND_Y   = 500;
  localparam int DEF_WALK_SPEED = 2;
  localparam int DEF_JUMP_VEL   = 12;
  localparam int DEF_GRAVITY    = 1;
  localparam int DEF_MAX_FALL   = 12;

  // Vertical velocity is a signed byte.
  localparam int VY_W = 8;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for one asynchronous button, plus a one-cycle
// rising-edge pulse taken from the synchronised level.
module btn_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift the raw button through the synchroniser and keep one cycle of history.
  always_comb begin
    meta_d = i_btn;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser and history flops.
  // NOTE: non-blocking assignments so every flop samples pre-edge values;
  // blocking here would collapse the two-stage chain into one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_level = sync_q;
  assign o_rise  = sync_q & ~prev_q;

endmodule

// File: rtl/character_motion.sv
// Per-frame motion controller: walks left/right with screen clamping and
// runs a ground/rise/fall jump with integer gravity, once per i_frame.
module character_motion
  import motion_pkg::*;
#(
  parameter int CORDW      = DEF_CORDW,
  parameter int H_RES      = DEF_H_RES,
  parameter int SPR_W_PIX  = DEF_SPR_W_PIX,
  parameter int INIT_X     = DEF_INIT_X,
  parameter int GROUND_Y   = DEF_GROUND_Y,
  parameter int WALK_SPEED = DEF_WALK_SPEED,
  parameter int JUMP_VEL   = DEF_JUMP_VEL,
  parameter int GRAVITY    = DEF_GRAVITY,
  parameter int MAX_FALL   = DEF_MAX_FALL
) (
  input  logic                    i_clk_pix,
  input  logic                    i_rst,
  input  logic                    i_frame,
  input  logic                    i_left,
  input  logic                    i_right,
  input  logic                    i_jump,
  output logic signed [CORDW-1:0] o_sprx,
  output logic signed [CORDW-1:0] o_spry,
  output logic                    o_face_left,
  output logic                    o_walking,
  output logic                    o_jumping
);

  // Constants sized to the arithmetic they take part in. Horizontal and
  // vertical sums use one extra bit so clamping sees the true result.
  localparam int X_MAX = H_RES - SPR_W_PIX;
  localparam logic signed [CORDW:0]   WALK_E   = (CORDW+1)'(WALK_SPEED);
  localparam logic signed [CORDW:0]   X_MAX_E  = (CORDW+1)'(X_MAX);
  localparam logic signed [CORDW:0]   GROUND_E = (CORDW+1)'(GROUND_Y);
  localparam logic signed [CORDW-1:0] X_MAX_C  = CORDW'(X_MAX);
  localparam logic signed [CORDW-1:0] INIT_C   = CORDW'(INIT_X);
  localparam logic signed [CORDW-1:0] GROUND_C = CORDW'(GROUND_Y);
  localparam logic signed [VY_W-1:0]  JUMP_V   = VY_W'(JUMP_VEL);
  localparam logic signed [VY_W-1:0]  GRAV_V   = VY_W'(GRAVITY);
  localparam logic signed [VY_W-1:0]  MAXF_V   = VY_W'(MAX_FALL);

  logic left_lvl, right_lvl, jump_rise;
  logic left_rise_unused, right_rise_unused, jump_lvl_unused;

  btn_sync u_sync_left (
    .i_clk   (i_clk_pix),
    .i_rst   (i_rst),
    .i_btn   (i_left),
    .o_level (left_lvl),
    .o_rise  (left_rise_unused)
  );

  btn_sync u_sync_right (
    .i_clk   (i_clk_pix),
    .i_rst   (i_rst),
    .i_btn   (i_right),
    .o_level (right_lvl),
    .o_rise  (right_rise_unused)
  );

  btn_sync u_sync_jump (
    .i_clk   (i_clk_pix),
    .i_rst   (i_rst),
    .i_btn   (i_jump),
    .o_level (jump_lvl_unused),
    .o_rise  (jump_rise)
  );

  motion_state_t           state_q, state_d;
  logic signed [CORDW-1:0] x_q, x_d;
  logic signed [CORDW-1:0] y_q, y_d;
  logic signed [VY_W-1:0]  vy_q, vy_d;
  logic                    face_q, face_d;
  logic                    walk_q, walk_d;
  logic                    jumping_q, jumping_d;
  logic                    pend_q, pend_d;

  logic signed [CORDW:0]   x_ext;
  logic signed [CORDW:0]   y_sum;
  logic signed [VY_W-1:0]  vy_inc;

  // Next-state: hold everything except on i_frame, where horizontal
  // motion and one step of the vertical state machine are applied together.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    vy_d      = vy_q;
    face_d    = face_q;
    walk_d    = walk_q;
    jumping_d = jumping_q;
    // A pending jump lives only until the next frame, used or not.
    pend_d    = i_frame ? 1'b0 : (pend_q | jump_rise);
    x_ext     = {x_q[CORDW-1], x_q};
    y_sum     = {y_q[CORDW-1], y_q} + {{(CORDW+1-VY_W){vy_q[VY_W-1]}}, vy_q};
    vy_inc    = vy_q + GRAV_V;

    if (i_frame) begin
      walk_d = left_lvl ^ right_lvl;
      if (left_lvl && !right_lvl) begin
        x_ext  = x_ext - WALK_E;
        face_d = 1'b1;
      end else if (right_lvl && !left_lvl) begin
        x_ext  = x_ext + WALK_E;
        face_d = 1'b0;
      end

      if (x_ext < 0) begin
        x_d = '0;
      end else if (x_ext > X_MAX_E) begin
        x_d = X_MAX_C;
      end else begin
        x_d = x_ext[CORDW-1:0];
      end

      case (state_q)
        MS_GROUND: begin
          if (pend_q) begin
            vy_d    = -JUMP_V;
            state_d = MS_RISE;
          end
        end
        MS_RISE: begin
          if (y_sum < 0) begin
            // Hit the top of the screen: stop dead and start falling.
            y_d     = '0;
            vy_d    = '0;
            state_d = MS_FALL;
          end else begin
            y_d  = y_sum[CORDW-1:0];
            vy_d = vy_inc;
            if (!vy_inc[VY_W-1]) begin
              state_d = MS_FALL;
            end
          end
        end
        MS_FALL: begin
          if (y_sum >= GROUND_E) begin
            y_d     = GROUND_C;
            vy_d    = '0;
            state_d = MS_GROUND;
          end else begin
            y_d  = y_sum[CORDW-1:0];
            vy_d = (vy_inc > MAXF_V) ? MAXF_V : vy_inc;
          end
        end
        default: begin
          state_d = MS_GROUND;
          y_d     = GROUND_C;
          vy_d    = '0;
        end
      endcase

      jumping_d = (state_d != MS_GROUND);
    end
  end

  // Motion registers; reset puts the character standing at its start point.
  always_ff @(posedge i_clk_pix or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= MS_GROUND;
      x_q       <= INIT_C;
      y_q       <= GROUND_C;
      vy_q      <= '0;
      face_q    <= 1'b0;
      walk_q    <= 1'b0;
      jumping_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      vy_q      <= vy_d;
      face_q    <= face_d;
      walk_q    <= walk_d;
      jumping_q <= jumping_d;
      pend_q    <= pend_d;
    end
  end

  assign o_sprx      = x_q;
  assign o_spry      = y_q;
  assign o_face_left = face_q;
  assign o_walking   = walk_q;
  assign o_jumping   = jumping_q;

endmodule

// File: doc/character_motion.md
# character_motion

Per-frame motion controller for the player character, directly upstream of the sprite renderer. Synchronises the left/right/jump buttons and runs a ground/rise/fall state machine with integer gravity once per video frame. Drives the renderer's position, facing, walking and jumping inputs, all registered and stable for the whole visible frame.

## Interface
- `CORDW`, 16: coordinate width (signed).
- `H_RES`, 800: horizontal screen width in pixels.
- `SPR_W_PIX`, 38: on-screen sprite width (sprite width × x-scale).
- `INIT_X`, 100: reset x position.
- `GROUND_Y`, 500: y of sprite top when standing (y grows downward).
- `WALK_SPEED`, 2: x step per frame.
- `JUMP_VEL`, 12: initial upward speed.
- `GRAVITY`, 1: vy increment per frame.
- `MAX_FALL`, 12: vy ceiling.
- `i_clk_pix`  in  1  pixel clock; single clock domain.
- `i_rst`  in  1  **asynchronous, active-high** reset.
- `i_frame`  in  1  one-cycle pulse at start of vertical blank.
- `i_left`, `i_right`, `i_jump`  in  1 each  raw buttons, asynchronous, active-high.
- `o_sprx`, `o_spry`  out  CORDW signed  sprite top-left.
- `o_face_left`  out  1  facing direction.
- `o_walking`  out  1  exactly one of left/right held at last update.
- `o_jumping`  out  1  airborne (state ≠ GROUND).

## Operation
- **Input stage**
  - Each button passes through a 2-FF synchroniser.
  - A jump rising edge (post-sync) sets a `jump_pend` flag.
  - `jump_pend` is cleared on every `i_frame`, whether consumed or not. A press while airborne is dropped.
- **Update rule**
  - State, position and outputs change only on cycles with `i_frame` = 1; all other cycles hold.
  - Left/right are sampled as their synchronised levels on that cycle.
- **Horizontal**
  - Left only: x −= WALK_SPEED, face_left ← 1.
  - Right only: x += WALK_SPEED, face_left ← 0.
  - Both or neither: x and face unchanged, walking ← 0.
  - x is clamped to [0, H_RES − SPR_W_PIX].
  - Compute in CORDW+1 bits before clamping; no wrap-around.
- **Vertical FSM**, vy signed 8-bit:
  - GROUND: if `jump_pend`, vy ← −JUMP_VEL and go to RISE; y unchanged this frame.
  - RISE: y ← y + vy, then vy ← vy + GRAVITY.
    - If the new vy ≥ 0, go to FALL.
    - If y + vy < 0, y ← 0, vy ← 0, go to FALL (ceiling).
  - FALL:
    - If y + vy ≥ GROUND_Y: y ← GROUND_Y, vy ← 0, go to GROUND.
    - Else: y ← y + vy, vy ← min(vy + GRAVITY, MAX_FALL).
- Jump and horizontal motion in the same frame are both applied.
- The illegal state encoding recovers to GROUND with y ← GROUND_Y.

## Timing
- **Reset values**: x = INIT_X, y = GROUND_Y, vy = 0, state GROUND, face_left 0, walking 0, jumping 0, jump_pend 0, synchronisers 0.
- Reset asserted mid-jump returns to the reset values immediately (asynchronous).
- An `i_frame` pulse coincident with reset is ignored.
- **Latency**:
  - Outputs update on the clock edge that samples `i_frame`, visible the next cycle.
  - Button-to-sample: 2 cycles of synchroniser delay. A jump edge arriving ≤ 2 cycles before `i_frame` may land in the next frame.
- **Jump profile** (defaults): frame F0 = jump accepted.
  - F12: apex y = GROUND_Y − 78, enter FALL.
  - F25: land.
  - o_jumping is high after F0 through F24, low after F25.

## Structure
- Package `motion_pkg`:
  - `typedef enum logic [1:0] {MS_GROUND, MS_RISE, MS_FALL} motion_state_t`.
  - Shared physics default constants.
- Sub-module `btn_sync`: 2-FF synchroniser plus rising-edge pulse output. Instantiated three times; only jump uses the edge output.

## Test plan
- **Reset**: assert i_rst mid-cycle with no clock → outputs immediately x=100, y=500, all flags 0.
- **Walk**:
  - Hold right for 10 frames → x = 120, walking=1, face_left=0.
  - Then both held → x stays 120, walking=0.
- **Clamp**:
  - Hold left from x=1 → x=0, stays 0.
  - Hold right near edge → x saturates at 762.
- **Jump**:
  - Pulse jump 1 cycle between frames → o_jumping rises after next frame.
  - y = 488 after F1, 422 at F12, 500 with o_jumping=0 after F25.
- **Airborne press**: pulse jump at F5 → ignored, landing still at F25, no re-jump.
- **Frame gating**: toggle buttons with i_frame held low for 1000 cycles → outputs unchanged.
